conv_enc_stream: RTL and testbench
==================================

Name: conv_enc_stream

Overview:
- Parametrised, handshaked successor to the fixed 128-bit encoder frame interface.
- Accepts a DATA_W-bit message frame on a valid/ready handshake and latches configuration (rate, constraint length, generator polynomials) per frame.
- Encodes one message bit per enabled clock with a runtime-configurable convolutional code, then presents the packed coded frame on a valid/ready output.
- Feeds the decoder side and the channel model in the endec datapath.

Parameters:
- DATA_W, 128: message bits per frame.
- MAX_K, 9: maximum constraint length supported.
- MAX_R, 3: maximum code-rate denominator; number of generator polynomials.
- OUT_W, (DATA_W+MAX_K-1)*MAX_R: coded frame width, derived; do not override.

Ports:
- sys_clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  clock enable; FSM and counters hold when low.
- i_code_rate  in  1  0 = rate 1/2, 1 = rate 1/3.
- i_constr_len  in  $clog2(MAX_K+1)  constraint length K; legal range 3..MAX_K.
- i_gen_poly_flat  in  MAX_K*MAX_R  polynomial r at [r*MAX_K +: MAX_K]; bit j taps message bit j cycles old.
- i_valid  in  1  input frame valid.
- o_ready  out  1  block can accept a frame.
- i_data_frame  in  DATA_W  message, bit 0 encoded first.
- o_valid  out  1  coded frame valid.
- i_ready  in  1  downstream accepts the coded frame.
- o_data_frame  out  OUT_W  coded symbols.
- o_busy  out  1  high in ENC or TAIL.

Behaviour:
- Reset values: o_ready=0 while rst is high, then 1 in IDLE; o_valid=0; o_busy=0; o_data_frame=0; shift state=0; FSM=IDLE.
- States: IDLE, ENC, TAIL, DONE.
- IDLE: o_ready=1. On i_valid&o_ready&en:
  - latch frame, rate, K and polynomials;
  - clear shift state, bit counter and o_data_frame;
  - go to ENC.
- ENC: one message bit n per en cycle.
  - window[0] = current bit; window[j] = bit n-j, with 0 before frame start.
  - Symbol r = XOR of (window[K-1:0] & poly_r[K-1:0]); poly bits at index K and above are ignored.
  - Rate 1/2: symbol 2 is forced to 0.
  - Write to o_data_frame[n*MAX_R + r].
  - After bit DATA_W-1, go to TAIL if the tail feature is compiled in, else DONE.
- TAIL: see Optional Feature.
- DONE: o_valid=1 and o_data_frame stable. On i_ready&en: o_valid drops the next cycle and the FSM returns to IDLE.
- o_ready=0 outside IDLE. A new frame is never accepted in the same cycle the previous frame is retired.
- Latency from acceptance to o_valid: DATA_W (+K-1 with tail) enabled cycles, plus 1.
- en low: all state frozen and outputs held. Handshakes are qualified by en.
- Config inputs changing after acceptance have no effect until the next frame.
- Illegal K (<3 or >MAX_K): clamp to MAX_K.
- Reset mid-frame: immediate return to IDLE, partial frame discarded, outputs at reset values.
- o_data_frame bits [DATA_W*MAX_R +: (MAX_K-1)*MAX_R] are zero unless tail symbols are written.

Optional Feature:
- Macro: CONV_TAIL_TERM_EN.
- Defined: after the message, the TAIL state encodes K-1 zero bits, driving the encoder back to the all-zero state.
  - Tail symbols are written at indices n = DATA_W .. DATA_W+K-2.
  - Positions for n >= DATA_W+K-1 (when K<MAX_K) stay 0.
- Undefined: TAIL state unreachable; frame is truncated; the whole tail region reads 0.

Test Plan:
- Rate 1/2, K=3, g0=9'h007, g1=9'h005, DATA_W bits 3..0 = 4'b1101, rest 0, no tail -> o_data_frame[11:0]=12'h40B, [17:12]=6'b011010, all higher bits 0; o_valid rises DATA_W+1 cycles after acceptance.
- Same frame with CONV_TAIL_TERM_EN, message bit DATA_W-1 = 1 -> tail symbols n=DATA_W, DATA_W+1 equal 3'b001 and 3'b011; encoder state is 0 at DONE.
- Rate 1/3, K=7, polys 133/171/165 octal, all-zero frame -> o_data_frame all 0; then all-ones frame -> the symbol at n=DATA_W-1 equals the parity of each full 7-tap polynomial.
- Backpressure: hold i_ready=0 for 20 cycles in DONE -> o_valid stays 1, data stable, o_ready stays 0; i_ready=1 -> o_valid falls and o_ready rises the next cycle.
- en toggled every other cycle during ENC -> output identical to the continuous-en result; latency doubles.
- Assert rst at bit 50 of ENC -> all outputs 0 during reset; o_ready=1 after release; the next frame encodes correctly with no residue from the aborted frame.

Source files
------------

// File: rtl/conv_enc_stream.sv
// ---------------------------------------------------------------------------
// conv_enc_stream
//
// Purpose:
//   Frame-based convolutional encoder with valid/ready handshakes on both
//   sides. A DATA_W-bit message frame is accepted together with its code
//   configuration: rate 1/2 or 1/3, constraint length K, and MAX_R generator
//   polynomials. The configuration is latched with the frame, so later
//   changes on the config inputs do not affect a frame already accepted.
//   The message is encoded one bit per enabled clock, bit 0 first. The
//   packed coded frame is then held on o_data_frame until downstream
//   accepts it.
//
// Optional feature (compile-time macro):
//   CONV_TAIL_TERM_EN - after the message, encode K-1 zero bits. This
//   returns the encoder to the all-zero state and appends the tail symbols
//   at n = DATA_W .. DATA_W+K-2. Without the macro the frame is truncated
//   and the whole tail region of o_data_frame reads 0.
//
// Ports:
//   sys_clk          clock
//   rst              asynchronous active-high reset
//   en               clock enable; FSM, counters and outputs hold when low
//   i_code_rate      0 = rate 1/2 (symbol 2 forced to 0), 1 = rate 1/3
//   i_constr_len     constraint length K, legal 3..MAX_K, otherwise MAX_K
//   i_gen_poly_flat  polynomial r at [r*MAX_K +: MAX_K]; bit j taps the
//                    message bit j cycles old
//   i_valid/o_ready  input frame handshake (qualified by en)
//   i_data_frame     message frame, bit 0 encoded first
//   o_valid/i_ready  coded frame handshake (qualified by en)
//   o_data_frame     coded symbols, symbol r of bit n at [n*MAX_R + r]
//   o_busy           high while encoding (ENC or TAIL)
// ---------------------------------------------------------------------------
module conv_enc_stream #(
  parameter int DATA_W = 128,
  parameter int MAX_K  = 9,
  parameter int MAX_R  = 3,
  parameter int OUT_W  = (DATA_W + MAX_K - 1) * MAX_R
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       i_code_rate,
  input  logic [$clog2(MAX_K+1)-1:0] i_constr_len,
  input  logic [MAX_K*MAX_R-1:0]     i_gen_poly_flat,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_W-1:0]          i_data_frame,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [OUT_W-1:0]           o_data_frame,
  output logic                       o_busy
);

  localparam int KW    = $clog2(MAX_K + 1);
  localparam int CNT_W = $clog2(DATA_W + MAX_K);
  localparam int OFF_W = $clog2(OUT_W);
  localparam int PW    = MAX_K * MAX_R;

  typedef enum logic [1:0] {IDLE, ENC, TAIL, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] frame_q;   // shifts right; bit 0 is the current bit
  logic              rate_q;
  logic [KW-1:0]     k_q;
  logic [PW-1:0]     poly_q;
  logic [MAX_K-2:0]  hist_q;    // hist_q[j-1] holds the bit j cycles old
  logic [CNT_W-1:0]  cnt_q;     // index n of the bit being encoded
  logic [OUT_W-1:0]  data_q;

  logic              accept;
  logic              msg_last;
  logic [KW-1:0]     k_sel;
  logic [MAX_K-1:0]  window;
  logic [MAX_K-1:0]  kmask;
  logic [MAX_R-1:0]  sym;
  logic [OFF_W-1:0]  sym_off;

  // Out-of-range constraint lengths fall back to the longest supported code.
  always_comb begin
    k_sel = i_constr_len;
    if (i_constr_len < KW'(3) || i_constr_len > KW'(MAX_K)) k_sel = KW'(MAX_K);
  end

  // Once the message has been shifted out, frame_q[0] is 0. The tail phase
  // therefore feeds zeros without any extra muxing.
  assign window   = {hist_q, frame_q[0]};
  assign msg_last = (cnt_q == CNT_W'(DATA_W - 1));
  assign sym_off  = OFF_W'(cnt_q) * OFF_W'(MAX_R);

  always_comb begin
    kmask = '0;
    for (int j = 0; j < MAX_K; j++) kmask[j] = (j < int'(k_q));
  end

  always_comb begin
    sym = '0;
    for (int r = 0; r < MAX_R; r++) begin
      sym[r] = ^(window & kmask & poly_q[r*MAX_K +: MAX_K]);
      if (r == 2 && !rate_q) sym[r] = 1'b0;
    end
  end

`ifdef CONV_TAIL_TERM_EN
  logic tail_last;
  // The last tail bit has index DATA_W + K - 2.
  assign tail_last = (cnt_q == CNT_W'(DATA_W - 2) + CNT_W'(k_q));
`endif

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = ~rst;
        if (i_valid && en) begin
          accept    = 1'b1;
          state_nxt = ENC;
        end
      end
      ENC: begin
        o_busy = 1'b1;
        if (en && msg_last) begin
`ifdef CONV_TAIL_TERM_EN
          state_nxt = TAIL;
`else
          state_nxt = DONE;
`endif
        end
      end
      TAIL: begin
        o_busy = 1'b1;
`ifdef CONV_TAIL_TERM_EN
        if (en && tail_last) state_nxt = DONE;
`else
        state_nxt = IDLE;  // unreachable without tail termination
`endif
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready && en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: frame/config capture, shift state, symbol writes.
  // NOTE: sequential state uses non-blocking assignments only. All flops
  // update together from values sampled before the edge.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      rate_q  <= 1'b0;
      k_q     <= KW'(MAX_K);
      poly_q  <= '0;
      hist_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else if (en) begin
      if (accept) begin
        frame_q <= i_data_frame;
        rate_q  <= i_code_rate;
        k_q     <= k_sel;
        poly_q  <= i_gen_poly_flat;
        hist_q  <= '0;
        cnt_q   <= '0;
        data_q  <= '0;
      end else if (o_busy) begin
        data_q[sym_off +: MAX_R] <= sym;
        frame_q <= {1'b0, frame_q[DATA_W-1:1]};
        hist_q  <= {hist_q[MAX_K-3:0], frame_q[0]};
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  assign o_data_frame = data_q;

endmodule

// File: tb/tb_conv_enc_stream.sv
// ---------------------------------------------------------------------------
// tb_conv_enc_stream
//
// Self-checking bench for conv_enc_stream. Expected coded frames come from a
// direct convolution model: symbol r of bit n is the XOR over taps j < K of
// poly_r[j] & msg[n-j], where msg is 0 outside the frame. Covered: reset,
// the directed K=3 vector, the K=7 133/171/165 code, backpressure, en
// toggling, random frames and configs (including illegal K), and reset
// mid-frame. Compile with +define+CONV_TAIL_TERM_EN to cover tail termination.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_enc_stream;

  localparam int DATA_W = 128;
  localparam int MAX_K  = 9;
  localparam int MAX_R  = 3;
  localparam int OUT_W  = (DATA_W + MAX_K - 1) * MAX_R;
  localparam int KW     = $clog2(MAX_K + 1);
  localparam int PW     = MAX_K * MAX_R;
`ifdef CONV_TAIL_TERM_EN
  localparam bit TAIL = 1'b1;
`else
  localparam bit TAIL = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              i_code_rate = 1'b0;
  logic [KW-1:0]     i_constr_len = '0;
  logic [PW-1:0]     i_gen_poly_flat = '0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [DATA_W-1:0] i_data_frame = '0;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic [OUT_W-1:0]  o_data_frame;
  logic              o_busy;

  int checks = 0;
  int errors = 0;

  conv_enc_stream #(.DATA_W(DATA_W), .MAX_K(MAX_K), .MAX_R(MAX_R)) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .en             (en),
    .i_code_rate    (i_code_rate),
    .i_constr_len   (i_constr_len),
    .i_gen_poly_flat(i_gen_poly_flat),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data_frame   (i_data_frame),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data_frame   (o_data_frame),
    .o_busy         (o_busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int eff_k(input int k);
    return (k < 3 || k > MAX_K) ? MAX_K : k;
  endfunction

  function automatic int exp_edges(input int k);
    return DATA_W + (TAIL ? eff_k(k) - 1 : 0);
  endfunction

  function automatic logic [OUT_W-1:0] model(input logic [DATA_W-1:0] f, input logic rate,
                                             input int k_in, input logic [PW-1:0] p);
    logic [OUT_W-1:0] res;
    int k, nlast;
    logic acc;
    res   = '0;
    k     = eff_k(k_in);
    nlast = DATA_W + (TAIL ? k - 1 : 0);
    for (int n = 0; n < nlast; n++) begin
      for (int r = 0; r < MAX_R; r++) begin
        acc = 1'b0;
        if (!(r == 2 && !rate)) begin
          for (int j = 0; j < k; j++) begin
            if (n - j >= 0 && n - j < DATA_W) acc = acc ^ (p[r*MAX_K + j] & f[n - j]);
          end
        end
        res[n*MAX_R + r] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] rand_frame();
    logic [DATA_W-1:0] f;
    for (int i = 0; i < DATA_W; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  // ---------------- drivers ----------------
  // Offers one frame, checks acceptance, then scrambles the config inputs
  // and runs until o_valid. en_mode: 0 continuous, 1 alternating (first
  // cycle low), 2 random. cycles counts clock edges after the acceptance
  // edge; en_cnt counts the enabled ones.
  task automatic run_frame(input logic [DATA_W-1:0] f, input logic rate, input logic [KW-1:0] k,
                           input logic [PW-1:0] p, input int en_mode,
                           output logic [OUT_W-1:0] got, output int cycles, output int en_cnt);
    @(negedge sys_clk);
    en = 1'b1; i_valid = 1'b1; i_data_frame = f;
    i_code_rate = rate; i_constr_len = k; i_gen_poly_flat = p;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready: o_ready=%b expected 1", o_ready);
    end
    @(negedge sys_clk);
    i_valid = 1'b0;
    i_data_frame = rand_frame();
    i_code_rate = 1'($urandom);
    i_constr_len = KW'($urandom);
    i_gen_poly_flat = PW'({$urandom, $urandom});
    checks++;
    if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL accept_state: o_ready=%b o_busy=%b expected 0/1", o_ready, o_busy);
    end
    cycles = 0; en_cnt = 0;
    while (o_valid !== 1'b1 && cycles < 2000) begin
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (cycles % 2 == 1);
        default: en = 1'($urandom_range(0, 1));
      endcase
      if (en) en_cnt++;
      cycles++;
      @(negedge sys_clk);
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL timeout: o_valid=%b after %0d cycles", o_valid, cycles);
    end
    got = o_data_frame;
  endtask

  task automatic retire();
    en = 1'b1; i_ready = 1'b1;
    @(negedge sys_clk);
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL retire: o_valid=%b o_ready=%b expected 0/1", o_valid, o_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_data_frame !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b busy=%b data_nonzero=%b expected all 0",
               o_ready, o_valid, o_busy, |o_data_frame);
    end
    rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: o_ready=%b expected 1", o_ready);
    end
  endtask

  task automatic test_k3_directed();
    logic [DATA_W-1:0] f;
    logic [PW-1:0] p;
    logic [OUT_W-1:0] got, exp;
    logic [OUT_W-1:0] hi;
    int cyc, ecnt;
    f = '0; f[3:0] = 4'b1101;
    p = {9'h000, 9'h005, 9'h007};
    run_frame(f, 1'b0, KW'(3), p, 0, got, cyc, ecnt);
    exp = model(f, 1'b0, 3, p);
    checks++;
    if (got[11:0] !== 12'h40B) begin
      errors++; $display("FAIL k3_low12: got %h expected 40b", got[11:0]);
    end
    checks++;
    if (got[17:12] !== 6'b011010) begin
      errors++; $display("FAIL k3_bits17_12: got %b expected 011010", got[17:12]);
    end
    hi = got >> 18;
    checks++;
    if (hi !== '0) begin
      errors++; $display("FAIL k3_upper_zero: got %h expected 0", hi);
    end
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL k3_model: got %h expected %h", got, exp);
    end
    // cycles + 1 counts the acceptance cycle itself.
    checks++;
    if (cyc + 1 !== exp_edges(3) + 1) begin
      errors++; $display("FAIL k3_latency: got %0d expected %0d", cyc + 1, exp_edges(3) + 1);
    end
    retire();

    f[DATA_W-1] = 1'b1;
    run_frame(f, 1'b0, KW'(3), p, 0, got, cyc, ecnt);
    exp = model(f, 1'b0, 3, p);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL k3_msb_model: got %h expected %h", got, exp);
    end
    hi = got >> (DATA_W * MAX_R);
`ifdef CONV_TAIL_TERM_EN
    checks++;
    if (hi[5:0] !== 6'b011001 || (hi >> 6) !== '0) begin
      errors++; $display("FAIL k3_tail_symbols: got %h expected 19", hi);
    end
`else
    checks++;
    if (hi !== '0) begin
      errors++; $display("FAIL k3_tail_region_zero: got %h expected 0", hi);
    end
`endif
    retire();
  endtask

  task automatic test_k7_standard();
    logic [PW-1:0] p;
    logic [OUT_W-1:0] got, exp;
    logic [MAX_R-1:0] par;
    int cyc, ecnt;
    p = {9'o165, 9'o171, 9'o133};
    for (int r = 0; r < MAX_R; r++) par[r] = ^p[r*MAX_K +: MAX_K];
    run_frame('0, 1'b1, KW'(7), p, 0, got, cyc, ecnt);
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL k7_zero_frame: got %h expected 0", got);
    end
    retire();
    run_frame('1, 1'b1, KW'(7), p, 0, got, cyc, ecnt);
    exp = model('1, 1'b1, 7, p);
    checks++;
    if (got[(DATA_W-1)*MAX_R +: MAX_R] !== par) begin
      errors++; $display("FAIL k7_full_parity: got %b expected %b",
                         got[(DATA_W-1)*MAX_R +: MAX_R], par);
    end
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL k7_ones_model: got %h expected %h", got, exp);
    end
    retire();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] f;
    logic [PW-1:0] p;
    logic [OUT_W-1:0] got, exp;
    int cyc, ecnt;
    f = rand_frame();
    p = PW'({$urandom, $urandom});
    run_frame(f, 1'b1, KW'(5), p, 0, got, cyc, ecnt);
    exp = model(f, 1'b1, 5, p);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL bp_model: got %h expected %h", got, exp);
    end
    i_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data_frame !== exp) begin
        errors++; $display("FAIL bp_hold cycle %0d: valid=%b ready=%b data_changed=%b expected 1/0/0",
                           i, o_valid, o_ready, o_data_frame !== exp);
      end
    end
    // i_ready without en must not retire the frame.
    i_ready = 1'b1; en = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (o_valid !== 1'b1 || o_data_frame !== exp) begin
      errors++; $display("FAIL bp_en_low: valid=%b expected 1", o_valid);
    end
    retire();
  endtask

  task automatic test_en_toggle();
    logic [DATA_W-1:0] f;
    logic [PW-1:0] p;
    logic [OUT_W-1:0] got0, got1;
    int cyc0, cyc1, e0, e1;
    f = rand_frame();
    p = PW'({$urandom, $urandom});
    run_frame(f, 1'b1, KW'(6), p, 0, got0, cyc0, e0);
    retire();
    run_frame(f, 1'b1, KW'(6), p, 1, got1, cyc1, e1);
    checks++;
    if (got1 !== model(f, 1'b1, 6, p)) begin
      errors++; $display("FAIL entog_model: got %h", got1);
    end
    checks++;
    if (got1 !== got0) begin
      errors++; $display("FAIL entog_same_output: got %h expected %h", got1, got0);
    end
    checks++;
    if (cyc1 !== 2 * exp_edges(6) || e1 !== exp_edges(6)) begin
      errors++; $display("FAIL entog_latency: cycles %0d enabled %0d expected %0d/%0d",
                         cyc1, e1, 2 * exp_edges(6), exp_edges(6));
    end
    retire();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] f;
    logic [PW-1:0] p;
    logic rate;
    logic [KW-1:0] k;
    logic [OUT_W-1:0] got, exp;
    int cyc, ecnt;
    for (int t = 0; t < 10; t++) begin
      f = rand_frame();
      p = PW'({$urandom, $urandom});
      rate = 1'($urandom);
      k = (t < 3) ? KW'(t * 7 % 16) : KW'($urandom_range(0, 15));  // 0, 7, 14 then random
      run_frame(f, rate, k, p, 2, got, cyc, ecnt);
      exp = model(f, rate, int'(k), p);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rand_model t=%0d k=%0d rate=%b: got %h expected %h",
                           t, k, rate, got, exp);
      end
      checks++;
      if (ecnt !== exp_edges(int'(k))) begin
        errors++; $display("FAIL rand_enabled_cycles t=%0d: got %0d expected %0d",
                           t, ecnt, exp_edges(int'(k)));
      end
      retire();
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] f;
    logic [PW-1:0] p;
    logic [OUT_W-1:0] got, exp;
    int cyc, ecnt;
    @(negedge sys_clk);
    en = 1'b1; i_valid = 1'b1; i_data_frame = '1;
    i_code_rate = 1'b1; i_constr_len = KW'(9); i_gen_poly_flat = '1;
    @(negedge sys_clk);
    i_valid = 1'b0;
    repeat (50) @(negedge sys_clk);
    rst = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_data_frame !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: ready=%b valid=%b busy=%b data_nonzero=%b expected all 0",
               o_ready, o_valid, o_busy, |o_data_frame);
    end
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL midrst_release: ready=%b busy=%b expected 1/0", o_ready, o_busy);
    end
    f = rand_frame();
    p = PW'({$urandom, $urandom});
    run_frame(f, 1'b0, KW'(4), p, 0, got, cyc, ecnt);
    exp = model(f, 1'b0, 4, p);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL midrst_next_frame: got %h expected %h", got, exp);
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_k3_directed();
    test_k7_standard();
    test_backpressure();
    test_en_toggle();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
